// File: rtl/shared_adder_pkg.sv
// Shared types and helpers for the tug-of-war shared adder arbiter.
package shared_adder_pkg;

  typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational unsigned adder.
module adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first set req bit searching from ptr+1 mod N.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned IdW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] idx,
  output logic           any
);

  logic [IdW-1:0] target;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    target = '0;
    // Offsets 1..N walk every requester once, ending on ptr itself.
    for (int j = 1; j <= int'(N); j++) begin
      target = IdW'((32'(ptr) + 32'(j)) % N);
      for (int i = 0; i < int'(N); i++) begin
        if (!any && req[i] && (target == IdW'(i))) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IdW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Round-robin shared WIDTH-bit adder with tagged, registered results.
// Optional SATURATE_EN: clamp rsp_sum to all ones on carry-out.
module shared_adder_arbiter
  import shared_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned N_REQ = 2,
  localparam int unsigned ID_W = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  input  logic                   rsp_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q, ptr_q;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_req, can_accept, xfer;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH:0]   full_sum;

  rr_arbiter #(
    .N   (N_REQ),
    .IdW (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (any_req)
  );

  // A held result frees the operand registers in the same cycle it retires.
  assign can_accept = (state_q == S_IDLE) | rsp_ready;
  assign xfer       = any_req & can_accept & ~reset;
  assign req_ready  = xfer ? gnt : '0;

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        win_a = req_a[i*WIDTH +: WIDTH];
        win_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = S_HOLD;
    end else if (state_q == S_HOLD && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (xfer) begin
        a_q   <= win_a;
        b_q   <= win_b;
        id_q  <= gnt_idx;
        ptr_q <= gnt_idx;
      end
    end
  end

  adder #(
    .WIDTH (WIDTH + 1)
  ) u_add (
    .a   ({1'b0, a_q}),
    .b   ({1'b0, b_q}),
    .sum (full_sum)
  );

  assign rsp_valid = (state_q == S_HOLD);
  assign rsp_id    = id_q;
  assign rsp_carry = full_sum[WIDTH];
`ifdef SATURATE_EN
  assign rsp_sum   = full_sum[WIDTH] ? '1 : full_sum[WIDTH-1:0];
`else
  assign rsp_sum   = full_sum[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Bench for shared_adder_arbiter: per-cycle reference model plus directed literal checks.
module tb_shared_adder_arbiter;

  localparam int W = 10;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [19:0]  req_a = '0;
  logic [19:0]  req_b = '0;
  logic [1:0]   req_ready;
  logic         rsp_valid;
  logic [0:0]   rsp_id;
  logic [9:0]   rsp_sum;
  logic         rsp_carry;
  logic         rsp_ready = 1'b0;

  int passed = 0;
  int total  = 0;

  shared_adder_arbiter #(
    .WIDTH (W),
    .N_REQ (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_sum(input int s);
`ifdef SATURATE_EN
    return (s > 1023) ? 1023 : s;
`else
    return s % 1024;
`endif
  endfunction

  // Reference model: result register contents and round-robin last winner.
  bit         m_valid = 0;
  int         m_id = 0, m_sum = 0, m_carry = 0, m_ptr = N - 1;
  bit         n_valid = 0;
  int         n_id = 0, n_sum = 0, n_carry = 0, n_ptr = N - 1;
  int         g, p, s;
  logic [1:0] exp_rdy;

  always @(negedge clk) begin
    g       = -1;
    exp_rdy = '0;
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        p = (m_ptr + k) % N;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    if (g >= 0 && (!m_valid || rsp_ready)) exp_rdy[g] = 1'b1;
    chk("model req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("model rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("model rsp_id", 32'(rsp_id), m_id);
    chk("model rsp_sum", 32'(rsp_sum), m_sum);
    chk("model rsp_carry", 32'(rsp_carry), m_carry);
    n_valid = m_valid; n_id = m_id; n_sum = m_sum; n_carry = m_carry; n_ptr = m_ptr;
    if (exp_rdy != 0) begin
      s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
      n_valid = 1;
      n_id    = g;
      n_carry = (s > 1023) ? 1 : 0;
      n_sum   = exp_sum(s);
      n_ptr   = g;
    end else if (m_valid && rsp_ready) begin
      n_valid = 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ptr = N - 1;
    end else begin
      m_valid = n_valid; m_id = n_id; m_sum = n_sum; m_carry = n_carry; m_ptr = n_ptr;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input int a0, input int b0, input int a1,
                     input int b1, input logic rr);
    req_valid = v;
    req_a     = {10'(a1), 10'(a0)};
    req_b     = {10'(b1), 10'(b0)};
    rsp_ready = rr;
  endtask

  int nres;

  initial begin
    // Reset state with both requesters asserting.
    drv(2'b11, 1, 1, 1, 1, 1'b1);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_sum", 32'(rsp_sum), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    drv(2'b00, 0, 0, 0, 0, 1'b1);

    // 1: req0 0+1
    go(); drv(2'b01, 0, 1, 0, 0, 1'b1);
    @(negedge clk); chk("t1 req_ready", 32'(req_ready), 32'b01);
    go(); drv(2'b00, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("t1 rsp_valid", 32'(rsp_valid), 1);
    chk("t1 rsp_id", 32'(rsp_id), 0);
    chk("t1 rsp_sum", 32'(rsp_sum), 1);
    chk("t1 rsp_carry", 32'(rsp_carry), 0);

    // 3: overflow then zero
    go(); drv(2'b01, 512, 512, 0, 0, 1'b1);
    @(negedge clk); chk("t3 req_ready", 32'(req_ready), 32'b01);
    go(); drv(2'b01, 0, 0, 0, 0, 1'b1);
`ifdef SATURATE_EN
    @(negedge clk); chk("t3 ovf sum", 32'(rsp_sum), 1023);
`else
    @(negedge clk); chk("t3 ovf sum", 32'(rsp_sum), 0);
`endif
    chk("t3 ovf carry", 32'(rsp_carry), 1);
    go(); drv(2'b00, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("t3 zero sum", 32'(rsp_sum), 0);
    chk("t3 zero carry", 32'(rsp_carry), 0);

    // 2: req1 256+255
    go(); drv(2'b10, 0, 0, 256, 255, 1'b1);
    @(negedge clk); chk("t2 req_ready", 32'(req_ready), 32'b10);
    go(); drv(2'b00, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("t2 rsp_id", 32'(rsp_id), 1);
    chk("t2 rsp_sum", 32'(rsp_sum), 511);
    chk("t2 rsp_carry", 32'(rsp_carry), 0);

    // 4: both valid, back-to-back alternating grants
    nres = 0;
    go(); drv(2'b11, 3, 4, 100, 200, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t4 grant", 32'(req_ready), (c % 2 == 0) ? 32'b01 : 32'b10);
      if (c > 0) begin
        chk("t4 rsp_id", 32'(rsp_id), 32'((c - 1) % 2));
        if (rsp_valid) nres++;
      end
      go();
    end
    drv(2'b00, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("t4 last id", 32'(rsp_id), 1);
    chk("t4 last sum", 32'(rsp_sum), 300);
    if (rsp_valid) nres++;
    chk("t4 results", 32'(nres), 6);

    // 5: held result stalls new grants
    go(); drv(2'b01, 7, 9, 0, 0, 1'b1);
    @(negedge clk); chk("t5 first grant", 32'(req_ready), 32'b01);
    go(); drv(2'b01, 1, 2, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5 stall ready", 32'(req_ready), 0);
      chk("t5 stall valid", 32'(rsp_valid), 1);
      chk("t5 stall sum", 32'(rsp_sum), 16);
      go();
    end
    drv(2'b01, 1, 2, 0, 0, 1'b1);
    @(negedge clk); chk("t5 release grant", 32'(req_ready), 32'b01);
    go(); drv(2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clk); chk("t5 new sum", 32'(rsp_sum), 3);

    // 6: async reset while holding
    go(); drv(2'b11, 5, 5, 6, 6, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6 async valid", 32'(rsp_valid), 0);
    chk("t6 async ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); chk("t6 first grant", 32'(req_ready), 32'b01);
    go(); drv(2'b00, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("t6 rsp_id", 32'(rsp_id), 0);
    chk("t6 rsp_sum", 32'(rsp_sum), 10);
    go();
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
